cycle_monitor: RTL
==================

CYCLE_MONITOR -- requirements
Module: cycle_monitor

Interface
REQ-001 Parameter CNT_WIDTH, default 16, width of cycle and change counters.
REQ-002 Parameter DATA_WIDTH, default 16, width of monitored core output.
REQ-003 Parameter HOLD_CYCLES, default 3, core-reset hold length in cycles (legal >= 1).
REQ-004 Parameter TIMEOUT, default 1000, RUN-cycle limit (legal 1 .. 2^CNT_WIDTH-1).
REQ-005 Parameter HIST_DEPTH, default 8, history FIFO depth (power of two, >= 2).
REQ-006 Clk  in  1  single clock; all state updates on rising edge.
REQ-007 Rst  in  1  reset, synchronous, active-high.
REQ-008 CoreRst  out  1  reset driven to monitored core.
REQ-009 DataIn  in  DATA_WIDTH  monitored core output.
REQ-010 HaltEn  in  1  enables halt-value detection.
REQ-011 HaltValue  in  DATA_WIDTH  value that ends the run.
REQ-012 Restart  in  1  single-cycle request to begin a new run.
REQ-013 ClockCount  out  CNT_WIDTH  RUN cycles elapsed.
REQ-014 ChangeCount  out  CNT_WIDTH  DataIn changes seen in RUN.
REQ-015 LastValue  out  DATA_WIDTH  most recent sampled DataIn.
REQ-016 State  out  2  HOLD=00, RUN=01, DONE=10, TIMEOUT=11.
REQ-017 Done, TimedOut  out  1 each  high exactly while State is DONE / TIMEOUT.
REQ-018 HistRdEn  in  1  pop oldest history entry.
REQ-019 HistRdData  out  DATA_WIDTH  oldest entry, first-word-fall-through.
REQ-020 HistEmpty  out  1; HistCount  out  clog2(HIST_DEPTH)+1; HistOverflow  out  1 sticky.

Function
REQ-021 HOLD: CoreRst=1; hold counter increments each cycle; after exactly HOLD_CYCLES HOLD cycles following Rst deassertion, State becomes RUN.
REQ-022 RUN: CoreRst=0; ClockCount increments by 1 each cycle (first RUN cycle registers 1).
REQ-023 RUN: DataIn != LastValue -> ChangeCount +1; LastValue <= DataIn every RUN cycle.
REQ-024 ChangeCount saturates at all-ones; never wraps.
REQ-025 RUN: HaltEn=1 and DataIn==HaltValue -> DONE next cycle; that cycle's count and change updates are included.
REQ-026 RUN: ClockCount reaching TIMEOUT -> TIMEOUT next cycle; halt takes precedence when both occur in the same cycle.
REQ-027 DONE: CoreRst=0; all counters, LastValue and history pushes frozen.
REQ-028 TIMEOUT: CoreRst=1; all counters frozen.
REQ-029 Restart in DONE or TIMEOUT -> HOLD; clears counters, LastValue, history and HistOverflow; Restart ignored in HOLD and RUN.
REQ-030 All outputs registered; no combinational path from DataIn to any output.

Reset
REQ-031 Rst=1 overrides all inputs (Restart, HistRdEn) in the same cycle.
REQ-032 Reset values: State=HOLD, CoreRst=1, ClockCount=0, ChangeCount=0, LastValue=0, Done=0, TimedOut=0, HistEmpty=1, HistCount=0, HistOverflow=0, HistRdData=0.
REQ-033 Rst asserted mid-RUN aborts the run; HOLD restarts its full HOLD_CYCLES count after Rst falls.

Configuration
REQ-034 Macro CYCLE_MONITOR_HISTORY_EN defined: HIST_DEPTH-entry FIFO; each counted change in RUN pushes new DataIn.
REQ-035 With macro, push when full drops the oldest entry and sets HistOverflow; simultaneous push and pop when full keeps HistCount, no overflow.
REQ-036 With macro, HistRdEn while HistEmpty=1 is ignored; pop takes effect next cycle.
REQ-037 Macro undefined: no storage; HistRdData=0, HistEmpty=1, HistCount=0, HistOverflow=0 constant; all other behaviour identical.

Verification
REQ-038 Rst high 3 cycles then low, HOLD_CYCLES=3 -> CoreRst high exactly 3 cycles after Rst falls; State=01 on 4th cycle; ClockCount=1 one cycle later.
REQ-039 HaltEn=1, HaltValue=16'h00AA, DataIn 1,2,3,AA on consecutive RUN cycles -> ChangeCount=4, LastValue=AA, Done=1, ClockCount frozen at 4.
REQ-040 TIMEOUT=10, DataIn constant -> TimedOut=1 with ClockCount=10, CoreRst=1; Restart pulse -> State=00, counters 0.
REQ-041 Macro defined, HIST_DEPTH=8, 10 distinct changes -> HistCount=8, HistOverflow=1, HistRdData=3rd value; 8 pops -> HistEmpty=1.
REQ-042 CNT_WIDTH=4, TIMEOUT=15, DataIn toggling every cycle -> ChangeCount saturates at 15, no wrap; Rst mid-RUN -> all reset values next cycle.

Source files
------------

// File: rtl/cycle_monitor.sv
// Run-cycle monitor: holds a core in reset, counts its RUN cycles and output changes, and stops on a halt value or timeout.
// Optional history FIFO of changed values is built when CYCLE_MONITOR_HISTORY_EN is defined.
module cycle_monitor #(
   parameter int CNT_WIDTH   = 16,
   parameter int DATA_WIDTH  = 16,
   parameter int HOLD_CYCLES = 3,
   parameter int TIMEOUT     = 1000,
   parameter int HIST_DEPTH  = 8
) (
   input  logic                          Clk,
   input  logic                          Rst,
   output logic                          CoreRst,
   input  logic [DATA_WIDTH-1:0]         DataIn,
   input  logic                          HaltEn,
   input  logic [DATA_WIDTH-1:0]         HaltValue,
   input  logic                          Restart,
   output logic [CNT_WIDTH-1:0]          ClockCount,
   output logic [CNT_WIDTH-1:0]          ChangeCount,
   output logic [DATA_WIDTH-1:0]         LastValue,
   output logic [1:0]                    State,
   output logic                          Done,
   output logic                          TimedOut,
   input  logic                          HistRdEn,
   output logic [DATA_WIDTH-1:0]         HistRdData,
   output logic                          HistEmpty,
   output logic [$clog2(HIST_DEPTH):0]   HistCount,
   output logic                          HistOverflow
);

   localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int HIST_AW = $clog2(HIST_DEPTH);
   localparam int HIST_CW = HIST_AW + 1;

   localparam logic [HOLD_W-1:0]    HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT);

   typedef enum logic [1:0] {
      S_HOLD    = 2'b00,
      S_RUN     = 2'b01,
      S_DONE    = 2'b10,
      S_TIMEOUT = 2'b11
   } state_t;

   state_t                  state_q, state_d;
   logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;
   logic [CNT_WIDTH-1:0]    clock_cnt_q, clock_cnt_d;
   logic [CNT_WIDTH-1:0]    change_cnt_q, change_cnt_d;
   logic [DATA_WIDTH-1:0]   last_value_q, last_value_d;
   logic                    core_rst_q, core_rst_d;
   logic                    done_q, done_d;
   logic                    timed_out_q, timed_out_d;
   logic                    data_changed;

   assign data_changed = (DataIn != last_value_q);

   always_comb begin
      // NOTE: every variable gets a default before the case so no latch is inferred.
      state_d      = state_q;
      hold_cnt_d   = hold_cnt_q;
      clock_cnt_d  = clock_cnt_q;
      change_cnt_d = change_cnt_q;
      last_value_d = last_value_q;
      unique case (state_q)
         S_HOLD: begin
            if (hold_cnt_q == HOLD_LAST) begin
               state_d    = S_RUN;
               hold_cnt_d = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end
         S_RUN: begin
            clock_cnt_d  = clock_cnt_q + CNT_WIDTH'(1);
            if (data_changed && (change_cnt_q != '1))
               change_cnt_d = change_cnt_q + CNT_WIDTH'(1);
            last_value_d = DataIn;
            // Halt wins over timeout when both land on the same cycle.
            if (HaltEn && (DataIn == HaltValue))
               state_d = S_DONE;
            else if (clock_cnt_d == TIMEOUT_VAL)
               state_d = S_TIMEOUT;
         end
         default: begin
            if (Restart) begin
               state_d      = S_HOLD;
               hold_cnt_d   = '0;
               clock_cnt_d  = '0;
               change_cnt_d = '0;
               last_value_d = '0;
            end
         end
      endcase
      core_rst_d  = (state_d == S_HOLD) || (state_d == S_TIMEOUT);
      done_d      = (state_d == S_DONE);
      timed_out_d = (state_d == S_TIMEOUT);
   end

   always_ff @(posedge Clk) begin
      // NOTE: sequential state uses non-blocking assignments; reset is synchronous and overrides everything.
      if (Rst) begin
         state_q      <= S_HOLD;
         hold_cnt_q   <= '0;
         clock_cnt_q  <= '0;
         change_cnt_q <= '0;
         last_value_q <= '0;
         core_rst_q   <= 1'b1;
         done_q       <= 1'b0;
         timed_out_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_cnt_q   <= hold_cnt_d;
         clock_cnt_q  <= clock_cnt_d;
         change_cnt_q <= change_cnt_d;
         last_value_q <= last_value_d;
         core_rst_q   <= core_rst_d;
         done_q       <= done_d;
         timed_out_q  <= timed_out_d;
      end
   end

   assign State       = state_q;
   assign CoreRst     = core_rst_q;
   assign ClockCount  = clock_cnt_q;
   assign ChangeCount = change_cnt_q;
   assign LastValue   = last_value_q;
   assign Done        = done_q;
   assign TimedOut    = timed_out_q;

`ifdef CYCLE_MONITOR_HISTORY_EN
   logic [DATA_WIDTH-1:0] hist_mem_q [HIST_DEPTH];
   logic [HIST_AW-1:0]    hist_wr_ptr_q, hist_wr_ptr_d;
   logic [HIST_AW-1:0]    hist_rd_ptr_q, hist_rd_ptr_d;
   logic [HIST_CW-1:0]    hist_cnt_q, hist_cnt_d;
   logic                  hist_ovf_q, hist_ovf_d;
   logic [DATA_WIDTH-1:0] hist_rd_data_q, hist_rd_data_d;
   logic                  hist_push, hist_pop, hist_clear, hist_full;

   always_comb begin
      hist_push      = (state_q == S_RUN) && data_changed;
      hist_clear     = ((state_q == S_DONE) || (state_q == S_TIMEOUT)) && Restart;
      hist_full      = (hist_cnt_q == HIST_CW'(HIST_DEPTH));
      hist_pop       = HistRdEn && (hist_cnt_q != '0);
      hist_wr_ptr_d  = hist_wr_ptr_q;
      hist_rd_ptr_d  = hist_rd_ptr_q;
      hist_cnt_d     = hist_cnt_q;
      hist_ovf_d     = hist_ovf_q;
      hist_rd_data_d = '0;
      if (!hist_clear) begin
         if (hist_push)
            hist_wr_ptr_d = hist_wr_ptr_q + HIST_AW'(1);
         // A push into a full FIFO retires the oldest entry; only an unpaired push counts as overflow.
         if (hist_push && hist_full) begin
            hist_rd_ptr_d = hist_rd_ptr_q + HIST_AW'(1);
            if (!hist_pop)
               hist_ovf_d = 1'b1;
         end else begin
            if (hist_pop)
               hist_rd_ptr_d = hist_rd_ptr_q + HIST_AW'(1);
            if (hist_push && !hist_pop)
               hist_cnt_d = hist_cnt_q + HIST_CW'(1);
            else if (!hist_push && hist_pop)
               hist_cnt_d = hist_cnt_q - HIST_CW'(1);
         end
         if (hist_cnt_d == '0)
            hist_rd_data_d = '0;
         else if (hist_push && (hist_wr_ptr_q == hist_rd_ptr_d))
            hist_rd_data_d = DataIn;
         else
            hist_rd_data_d = hist_mem_q[hist_rd_ptr_d];
      end else begin
         hist_wr_ptr_d = '0;
         hist_rd_ptr_d = '0;
         hist_cnt_d    = '0;
         hist_ovf_d    = 1'b0;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         hist_wr_ptr_q  <= '0;
         hist_rd_ptr_q  <= '0;
         hist_cnt_q     <= '0;
         hist_ovf_q     <= 1'b0;
         hist_rd_data_q <= '0;
      end else begin
         hist_wr_ptr_q  <= hist_wr_ptr_d;
         hist_rd_ptr_q  <= hist_rd_ptr_d;
         hist_cnt_q     <= hist_cnt_d;
         hist_ovf_q     <= hist_ovf_d;
         hist_rd_data_q <= hist_rd_data_d;
      end
   end

   // NOTE: storage is not reset; the count and pointers alone define which entries are valid.
   always_ff @(posedge Clk) begin
      if (hist_push && !Rst)
         hist_mem_q[hist_wr_ptr_q] <= DataIn;
   end

   assign HistRdData   = hist_rd_data_q;
   assign HistEmpty    = (hist_cnt_q == '0);
   assign HistCount    = hist_cnt_q;
   assign HistOverflow = hist_ovf_q;
`else
   logic unused_hist_rd_en;
   assign unused_hist_rd_en = HistRdEn;

   assign HistRdData   = '0;
   assign HistEmpty    = 1'b1;
   assign HistCount    = '0;
   assign HistOverflow = 1'b0;
`endif

endmodule
